// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the 1080p60 video timing source:
//   - default raster timing (2200x1125 total, 1920x1080 active)
//   - colour constants and the colour-bar lookup
//   - test-pattern select enum
// No ports; imported by video_timing_gen and video_pattern_gen.
// -----------------------------------------------------------------------------
package video_pkg;

  // 1080p60 raster timing defaults
  localparam int unsigned H_ACTIVE_1080P = 1920;
  localparam int unsigned H_FP_1080P     = 88;
  localparam int unsigned H_SYNC_1080P   = 44;
  localparam int unsigned H_BP_1080P     = 148;
  localparam int unsigned V_ACTIVE_1080P = 1080;
  localparam int unsigned V_FP_1080P     = 4;
  localparam int unsigned V_SYNC_1080P   = 5;
  localparam int unsigned V_BP_1080P     = 36;
  localparam int unsigned CHECK_LOG2_DEF = 5;

  // Colour constants, packed as {R, G, B}
  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;
  localparam logic [23:0] RGB_GREY    = 24'h808080;

  // Test-pattern select encoding (matches pat_sel_i)
  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_GREY  = 2'd2,
    PAT_CHECK = 2'd3
  } pat_e;

  // Colour-bar table: bar 0 is leftmost
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = RGB_WHITE;
      3'd1:    rgb = RGB_YELLOW;
      3'd2:    rgb = RGB_CYAN;
      3'd3:    rgb = RGB_GREEN;
      3'd4:    rgb = RGB_MAGENTA;
      3'd5:    rgb = RGB_RED;
      3'd6:    rgb = RGB_BLUE;
      3'd7:    rgb = RGB_BLACK;
      default: rgb = RGB_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// -----------------------------------------------------------------------------
// video_pattern_gen
// Registered test-pattern RGB generator. Produces the colour of the pixel at
// (hpos_i, vpos_i) for the selected pattern, forced to black outside active
// video. The output register advances only on cen_i so it stays aligned with
// the timing outputs registered in the top level.
// Ports:
//   clk_i, rst_i  : pixel clock, synchronous active-high reset
//   cen_i         : pixel clock enable
//   hpos_i/vpos_i : counter position of the pixel being generated
//   active_i      : pixel lies in active video (D_sync)
//   pat_i         : pattern in force for the current frame
//   rgb_o         : registered {R,G,B}
// -----------------------------------------------------------------------------
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_1080P,
  parameter int unsigned CHECK_LOG2 = CHECK_LOG2_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [11:0] hpos_i,
  input  logic [10:0] vpos_i,
  input  logic        active_i,
  input  pat_e        pat_i,
  output logic [23:0] rgb_o
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;
  // Selects the checkerboard bit in both coordinates
  localparam logic [11:0] CHECK_MASK = 12'(1) << CHECK_LOG2;

  logic [2:0]  bar_idx_s;
  logic        check_s;
  logic [23:0] rgb_d;
  logic [23:0] rgb_q;

  // Bar index = hpos / BAR_W as a compare chain; scanning downward leaves the
  // smallest boundary that hpos lies below.
  always_comb begin
    bar_idx_s = 3'd7;
    for (int k = 7; k >= 1; k--) begin
      if (hpos_i < 12'(BAR_W * k)) begin
        bar_idx_s = 3'(k - 1);
      end else begin
        bar_idx_s = bar_idx_s;
      end
    end
  end

  // Checkerboard square parity: h[CHECK_LOG2] xor v[CHECK_LOG2]
  always_comb begin
    check_s = ^((hpos_i ^ {1'b0, vpos_i}) & CHECK_MASK);
  end

  // Next RGB: pattern colour in active video, black elsewhere; hold off-enable
  always_comb begin
    rgb_d = rgb_q;
    if (cen_i) begin
      if (active_i) begin
        case (pat_i)
          PAT_BARS:  rgb_d = bar_rgb(bar_idx_s);
          PAT_RAMP:  rgb_d = {3{hpos_i[7:0]}};
          PAT_GREY:  rgb_d = RGB_GREY;
          PAT_CHECK: rgb_d = check_s ? RGB_WHITE : RGB_BLACK;
          default:   rgb_d = RGB_BLACK;
        endcase
      end else begin
        rgb_d = RGB_BLACK;
      end
    end else begin
      rgb_d = rgb_q;
    end
  end

  // RGB output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_q <= 24'h000000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Raster timing source (1080p60 by default). Free-running h/v counters advance
// on cen_i; region decode of the counters is registered one enable later so
// blanking, sync, RGB, position and frame outputs all stay mutually aligned.
// The test pattern is latched at pixel (0,0) so a frame never changes pattern
// part way through.
// Ports:
//   clk_i         : pixel-domain clock
//   rst_i         : synchronous active-high reset (wins over cen_i)
//   cen_i         : pixel clock enable; all state advances only when high
//   pat_sel_i     : test pattern select (0 bars, 1 ramp, 2 grey, 3 checker)
//   vh_blank_o    : {Vblank, Hblank}
//   dvh_sync_o    : {D_sync, Vsync, Hsync}, positive polarity
//   vid_rgb_o     : {R,G,B}, black outside active video
//   hpos_o/vpos_o : position of the pixel currently on the outputs
//   frame_cnt_o   : frame counter, 0 for the first frame after reset
//   frame_start_o : high with pixel (0,0)
// -----------------------------------------------------------------------------
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_1080P,
  parameter int unsigned H_FP       = H_FP_1080P,
  parameter int unsigned H_SYNC     = H_SYNC_1080P,
  parameter int unsigned H_BP       = H_BP_1080P,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_1080P,
  parameter int unsigned V_FP       = V_FP_1080P,
  parameter int unsigned V_SYNC     = V_SYNC_1080P,
  parameter int unsigned V_BP       = V_BP_1080P,
  parameter int unsigned CHECK_LOG2 = CHECK_LOG2_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [1:0]  pat_sel_i,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [23:0] vid_rgb_o,
  output logic [11:0] hpos_o,
  output logic [10:0] vpos_o,
  output logic [3:0]  frame_cnt_o,
  output logic        frame_start_o
);

  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  // Counter state
  logic [11:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  pat_e        pat_q, pat_d;
  logic        frame_seen_q, frame_seen_d;

  // Registered outputs
  logic [1:0]  vh_blank_q, vh_blank_d;
  logic [2:0]  dvh_sync_q, dvh_sync_d;
  logic [11:0] hpos_q, hpos_d;
  logic [10:0] vpos_q, vpos_d;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic        frame_start_q, frame_start_d;

  // Decode of the current counter position
  logic h_active_s, v_active_s, hsync_s, vsync_s;
  logic h_last_s, v_last_s, frame_start_s;
  pat_e pat_cur_s;

  // Region decode and frame-start detection on the counters
  always_comb begin
    h_active_s    = (h_q < H_ACT_END);
    v_active_s    = (v_q < V_ACT_END);
    hsync_s       = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
    vsync_s       = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);
    h_last_s      = (h_q == H_LAST);
    v_last_s      = (v_q == V_LAST);
    frame_start_s = cen_i && (h_q == 12'd0) && (v_q == 11'd0);
    // The newly sampled pattern applies to pixel (0,0) itself
    if (frame_start_s) begin
      pat_cur_s = pat_e'(pat_sel_i);
    end else begin
      pat_cur_s = pat_q;
    end
  end

  // Next-state for counters and outputs; everything holds when cen_i is low
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    pat_d         = pat_q;
    frame_seen_d  = frame_seen_q;
    vh_blank_d    = vh_blank_q;
    dvh_sync_d    = dvh_sync_q;
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    frame_cnt_d   = frame_cnt_q;
    frame_start_d = frame_start_q;
    if (cen_i) begin
      if (h_last_s) begin
        h_d = 12'd0;
        if (v_last_s) begin
          v_d = 11'd0;
        end else begin
          v_d = v_q + 11'd1;
        end
      end else begin
        h_d = h_q + 12'd1;
        v_d = v_q;
      end

      pat_d         = pat_cur_s;
      vh_blank_d    = {~v_active_s, ~h_active_s};
      dvh_sync_d    = {h_active_s & v_active_s, vsync_s, hsync_s};
      hpos_d        = h_q;
      vpos_d        = v_q;
      frame_start_d = frame_start_s;

      // First frame after reset keeps count 0; later frames increment
      if (frame_start_s) begin
        frame_seen_d = 1'b1;
        if (frame_seen_q) begin
          frame_cnt_d = frame_cnt_q + 4'd1;
        end else begin
          frame_cnt_d = 4'd0;
        end
      end else begin
        frame_seen_d = frame_seen_q;
        frame_cnt_d  = frame_cnt_q;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end
  end

  // State and output registers; reset overrides cen_i
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q           <= 12'd0;
      v_q           <= 11'd0;
      pat_q         <= PAT_BARS;
      frame_seen_q  <= 1'b0;
      vh_blank_q    <= 2'b00;
      dvh_sync_q    <= 3'b000;
      hpos_q        <= 12'd0;
      vpos_q        <= 11'd0;
      frame_cnt_q   <= 4'd0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      pat_q         <= pat_d;
      frame_seen_q  <= frame_seen_d;
      vh_blank_q    <= vh_blank_d;
      dvh_sync_q    <= dvh_sync_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  video_pattern_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .CHECK_LOG2 (CHECK_LOG2)
  ) u_pattern (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cen_i    (cen_i),
    .hpos_i   (h_q),
    .vpos_i   (v_q),
    .active_i (h_active_s & v_active_s),
    .pat_i    (pat_cur_s),
    .rgb_o    (vid_rgb_o)
  );

  assign vh_blank_o    = vh_blank_q;
  assign dvh_sync_o    = dvh_sync_q;
  assign hpos_o        = hpos_q;
  assign vpos_o        = vpos_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
// Instance "a" runs the real 1080p timing for line-level checks; instance "b"
// uses a shrunken raster (80x50 total, 64x40 active, 8 px checker squares) so
// whole frames fit in a short run.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a (1080p)
  logic        rst_a, cen_a;
  logic [1:0]  pat_a;
  logic [1:0]  vh_blank_a;
  logic [2:0]  dvh_sync_a;
  logic [23:0] vid_rgb_a;
  logic [11:0] hpos_a;
  logic [10:0] vpos_a;
  logic [3:0]  frame_cnt_a;
  logic        frame_start_a;

  // Instance b (small raster)
  logic        rst_b, cen_b;
  logic [1:0]  pat_b;
  logic [1:0]  vh_blank_b;
  logic [2:0]  dvh_sync_b;
  logic [23:0] vid_rgb_b;
  logic [11:0] hpos_b;
  logic [10:0] vpos_b;
  logic [3:0]  frame_cnt_b;
  logic        frame_start_b;

  video_timing_gen dut_a (
    .clk_i(clk), .rst_i(rst_a), .cen_i(cen_a), .pat_sel_i(pat_a),
    .vh_blank_o(vh_blank_a), .dvh_sync_o(dvh_sync_a), .vid_rgb_o(vid_rgb_a),
    .hpos_o(hpos_a), .vpos_o(vpos_a), .frame_cnt_o(frame_cnt_a),
    .frame_start_o(frame_start_a)
  );

  video_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_BP(8),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(5),
    .CHECK_LOG2(3)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b), .cen_i(cen_b), .pat_sel_i(pat_b),
    .vh_blank_o(vh_blank_b), .dvh_sync_o(dvh_sync_b), .vid_rgb_o(vid_rgb_b),
    .hpos_o(hpos_b), .vpos_o(vpos_b), .frame_cnt_o(frame_cnt_b),
    .frame_start_o(frame_start_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int          h;
    logic [1:0]  blank;
    logic [2:0]  sync;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs change at negedge, outputs are read at negedge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_a(input int h, input int v, input int budget, input string tag);
    int k = 0;
    while (!(hpos_a == 12'(h) && vpos_a == 11'(v)) && k < budget) begin
      tick();
      k++;
    end
    if (!(hpos_a == 12'(h) && vpos_a == 11'(v))) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: position (%0d,%0d) not reached, at (%0d,%0d)", tag, h, v, hpos_a, vpos_a);
    end
  endtask

  task automatic wait_b(input int h, input int v, input int budget, input string tag);
    int k = 0;
    while (!(hpos_b == 12'(h) && vpos_b == 11'(v)) && k < budget) begin
      tick();
      k++;
    end
    if (!(hpos_b == 12'(h) && vpos_b == 11'(v))) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: position (%0d,%0d) not reached, at (%0d,%0d)", tag, h, v, hpos_b, vpos_b);
    end
  endtask

  initial begin
    int c0, hs, hb, vb, vs, ds, n, hold_err;
    int vs_first, vs_last, vb_first;
    logic [23:0] rgb_mid;
    logic [56:0] snap;

    // Line 0 of a bars frame: {hpos, blank, sync, rgb}
    tbl[0]  = '{0,    2'b00, 3'b100, 24'hFFFFFF};
    tbl[1]  = '{239,  2'b00, 3'b100, 24'hFFFFFF};
    tbl[2]  = '{240,  2'b00, 3'b100, 24'hFFFF00};
    tbl[3]  = '{480,  2'b00, 3'b100, 24'h00FFFF};
    tbl[4]  = '{720,  2'b00, 3'b100, 24'h00FF00};
    tbl[5]  = '{960,  2'b00, 3'b100, 24'hFF00FF};
    tbl[6]  = '{1200, 2'b00, 3'b100, 24'hFF0000};
    tbl[7]  = '{1439, 2'b00, 3'b100, 24'hFF0000};
    tbl[8]  = '{1440, 2'b00, 3'b100, 24'h0000FF};
    tbl[9]  = '{1680, 2'b00, 3'b100, 24'h000000};
    tbl[10] = '{1919, 2'b00, 3'b100, 24'h000000};
    tbl[11] = '{1920, 2'b01, 3'b000, 24'h000000};
    tbl[12] = '{2007, 2'b01, 3'b000, 24'h000000};
    tbl[13] = '{2008, 2'b01, 3'b001, 24'h000000};
    tbl[14] = '{2030, 2'b01, 3'b001, 24'h000000};
    tbl[15] = '{2051, 2'b01, 3'b001, 24'h000000};
    tbl[16] = '{2052, 2'b01, 3'b000, 24'h000000};
    tbl[17] = '{2199, 2'b01, 3'b000, 24'h000000};

    rst_a = 1'b1; cen_a = 1'b0; pat_a = 2'd0;
    rst_b = 1'b1; cen_b = 1'b0; pat_b = 2'd0;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    check("rst_blank", 32'(vh_blank_a), 32'h0);
    check("rst_sync", 32'(dvh_sync_a), 32'h0);
    check("rst_rgb", 32'(vid_rgb_a), 32'h0);
    check("rst_hpos", 32'(hpos_a), 32'h0);
    check("rst_vpos", 32'(vpos_a), 32'h0);
    check("rst_fcnt", 32'(frame_cnt_a), 32'h0);
    check("rst_fstart", 32'(frame_start_a), 32'h0);

    // First enable after reset emits pixel (0,0)
    rst_a = 1'b0; cen_a = 1'b1;
    tick();
    check("first_fstart", 32'(frame_start_a), 32'h1);
    check("first_fcnt", 32'(frame_cnt_a), 32'h0);
    check("first_vpos", 32'(vpos_a), 32'h0);

    // Table-driven line 0
    for (int i = 0; i < 18; i++) begin
      wait_a(tbl[i].h, 0, 2300, $sformatf("line0_h%0d", tbl[i].h));
      check($sformatf("line0_h%0d_blank", tbl[i].h), 32'(vh_blank_a), 32'(tbl[i].blank));
      check($sformatf("line0_h%0d_sync", tbl[i].h), 32'(dvh_sync_a), 32'(tbl[i].sync));
      check($sformatf("line0_h%0d_rgb", tbl[i].h), 32'(vid_rgb_a), 32'(tbl[i].rgb));
    end
    check("fstart_low_midframe", 32'(frame_start_a), 32'h0);

    // Line period and hsync width over line 1
    wait_a(0, 1, 10, "line1_start");
    hs = 0; hb = 0;
    for (int i = 0; i < 2200; i++) begin
      hs += int'(dvh_sync_a[0]);
      hb += int'(vh_blank_a[0]);
      tick();
    end
    check("line_period_hpos", 32'(hpos_a), 32'd0);
    check("line_period_vpos", 32'(vpos_a), 32'd2);
    check("hsync_width", 32'(hs), 32'd44);
    check("hblank_width", 32'(hb), 32'd280);

    // Ramp pattern
    rst_a = 1'b1; pat_a = 2'd1;
    tick();
    rst_a = 1'b0;
    tick();
    check("ramp_h0", 32'(vid_rgb_a), 32'h000000);
    wait_a(255, 0, 300, "ramp_h255");
    check("ramp_h255", 32'(vid_rgb_a), 32'hFFFFFF);
    tick();
    check("ramp_h256", 32'(vid_rgb_a), 32'h000000);
    wait_a(300, 0, 100, "ramp_h300");
    check("ramp_h300", 32'(vid_rgb_a), 32'h2C2C2C);
    wait_a(1919, 0, 2000, "ramp_h1919");
    check("ramp_h1919", 32'(vid_rgb_a), 32'h7F7F7F);

    // Grey pattern; a mid-frame select change must not take effect
    rst_a = 1'b1; pat_a = 2'd2;
    tick();
    rst_a = 1'b0;
    tick();
    check("grey_h0", 32'(vid_rgb_a), 32'h808080);
    pat_a = 2'd0;
    wait_a(100, 0, 200, "grey_h100");
    check("grey_h100_hold_pat", 32'(vid_rgb_a), 32'h808080);
    wait_a(1920, 0, 2000, "grey_h1920");
    check("grey_h1920_blank", 32'(vid_rgb_a), 32'h000000);

    // cen_i on every other clock: hold between enables, 4400-clock line
    rst_a = 1'b1; cen_a = 1'b0; pat_a = 2'd0;
    tick();
    rst_a = 1'b0; cen_a = 1'b1;
    tick();
    check("cen2_first_fstart", 32'(frame_start_a), 32'h1);
    c0 = cyc;
    hold_err = 0;
    for (int i = 0; i < 10000; i++) begin
      cen_a = ~cen_a;
      snap = {vh_blank_a, dvh_sync_a, vid_rgb_a, hpos_a, vpos_a, frame_cnt_a, frame_start_a};
      tick();
      if (!cen_a && snap !== {vh_blank_a, dvh_sync_a, vid_rgb_a, hpos_a, vpos_a, frame_cnt_a, frame_start_a}) begin
        hold_err++;
      end
      if (hpos_a == 12'd0 && vpos_a == 11'd1) break;
    end
    check("cen2_line_clocks", 32'(cyc - c0), 32'd4400);
    check("cen2_hold_errors", 32'(hold_err), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      if (hpos_a == 12'd1000) break;
      cen_a = ~cen_a;
      tick();
    end
    check("cen2_reach_h1000", 32'(hpos_a), 32'd1000);
    check("cen2_h1000_rgb", 32'(vid_rgb_a), 32'hFF00FF);
    // Reset with cen_i low still clears everything on the next edge
    rst_a = 1'b1; cen_a = 1'b0;
    tick();
    check("midrst_blank", 32'(vh_blank_a), 32'h0);
    check("midrst_sync", 32'(dvh_sync_a), 32'h0);
    check("midrst_rgb", 32'(vid_rgb_a), 32'h0);
    check("midrst_hpos", 32'(hpos_a), 32'h0);
    check("midrst_vpos", 32'(vpos_a), 32'h0);
    check("midrst_fstart", 32'(frame_start_a), 32'h0);
    rst_a = 1'b0;

    // Small raster: one full frame with a mid-frame switch to checkerboard
    rst_b = 1'b0; cen_b = 1'b1; pat_b = 2'd0;
    tick();
    check("b_first_fstart", 32'(frame_start_b), 32'h1);
    check("b_first_fcnt", 32'(frame_cnt_b), 32'h0);
    check("b_first_rgb_bars", 32'(vid_rgb_b), 32'hFFFFFF);
    n = 0; vb = 0; vs = 0; ds = 0;
    vs_first = -1; vs_last = -1; vb_first = -1;
    rgb_mid = 24'h0;
    for (int i = 0; i < 5000; i++) begin
      if (i > 0 && frame_start_b) break;
      vb += int'(vh_blank_b[1]);
      vs += int'(dvh_sync_b[1]);
      ds += int'(dvh_sync_b[2]);
      if (dvh_sync_b[1] && vs_first < 0) vs_first = int'(vpos_b);
      if (dvh_sync_b[1]) vs_last = int'(vpos_b);
      if (vh_blank_b[1] && vb_first < 0) vb_first = int'(vpos_b);
      if (hpos_b == 12'd8 && vpos_b == 11'd10) rgb_mid = vid_rgb_b;
      if (hpos_b == 12'd20 && vpos_b == 11'd5) pat_b = 2'd3;
      tick();
      n++;
    end
    check("b_frame_period", 32'(n), 32'd4000);
    check("b_vblank_cycles", 32'(vb), 32'd800);
    check("b_vsync_cycles", 32'(vs), 32'd240);
    check("b_dsync_cycles", 32'(ds), 32'd2560);
    check("b_vsync_first_line", 32'(vs_first), 32'd42);
    check("b_vsync_last_line", 32'(vs_last), 32'd44);
    check("b_vblank_first_line", 32'(vb_first), 32'd40);
    check("b_midframe_still_bars", 32'(rgb_mid), 32'hFFFF00);
    check("b_frame2_fcnt", 32'(frame_cnt_b), 32'h1);
    check("b_frame2_vpos", 32'(vpos_b), 32'h0);
    check("b_check_0_0", 32'(vid_rgb_b), 32'h000000);
    wait_b(8, 0, 20, "b_check_8_0");
    check("b_check_8_0", 32'(vid_rgb_b), 32'hFFFFFF);
    wait_b(0, 8, 700, "b_check_0_8");
    check("b_check_0_8", 32'(vid_rgb_b), 32'hFFFFFF);
    wait_b(8, 8, 20, "b_check_8_8");
    check("b_check_8_8", 32'(vid_rgb_b), 32'h000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
